// File: rtl/ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller: state
// encoding, hold-counter sizing and a constant clog2 helper.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } ctrl_state_e;

  // Default number of cycles the DONE strobe is stretched.
  localparam int DONE_HOLD_DEFAULT = 32;

  // Hold counter width; covers hold lengths up to 255.
  localparam int HOLD_CNT_W = 8;

  // Ceiling log2, usable in constant expressions (port widths).
  function automatic int ctrl_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/control_hold_counter.sv
// Counts cycles while enabled and flags the last cycle of a HOLD-long
// window. Clear has priority over enable; the count saturates at HOLD-1.
module control_hold_counter
  import ctrl_pkg::*;
#(
  parameter int HOLD = DONE_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [HOLD_CNT_W-1:0] LAST = HOLD_CNT_W'(HOLD - 1);

  logic [HOLD_CNT_W-1:0] count_reg;
  logic [HOLD_CNT_W-1:0] count_next;

  // Next count: clear, advance while enabled, or hold at the last value.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != LAST)) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Asserted during the final enabled cycle of the window.
  assign expired = en && (count_reg == LAST);

endmodule

// File: rtl/control_mult_seq.sv
// Control FSM for a shift-add multiplier: loads operands, runs WIDTH
// check/add/shift iterations, then holds DONE for DONE_HOLD cycles.
// Outputs are decoded from the registered state only.
module control_mult_seq
  import ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DONE_HOLD  = DONE_HOLD_DEFAULT,
  parameter int EARLY_EXIT = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               INIT,
  input  logic                               LSB,
  input  logic                               Z,
  input  logic                               ABORT,
  output logic                               LD,
  output logic                               RST_ACC,
  output logic                               ADD,
  output logic                               SH,
  output logic                               DONE,
  output logic                               BUSY,
  output logic [ctrl_clog2(WIDTH+1)-1:0]     ITER
);

  localparam int                ITER_W    = ctrl_clog2(WIDTH + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);
  localparam logic [ITER_W-1:0] ITER_FULL = ITER_W'(WIDTH);

  ctrl_state_e       state_reg;
  ctrl_state_e       state_next;
  logic [ITER_W-1:0] iter_reg;
  logic [ITER_W-1:0] iter_next;
  logic              hold_en;
  logic              hold_clr;
  logic              hold_expired;

  // The hold counter runs only in DONE and is cleared whenever the FSM
  // is about to be anywhere else, so it always starts DONE at zero.
  assign hold_en  = (state_reg == S_DONE);
  assign hold_clr = (state_next != S_DONE);

  control_hold_counter #(
    .HOLD (DONE_HOLD)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (hold_en),
    .clr     (hold_clr),
    .expired (hold_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; ABORT overrides every transition outside IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (INIT) state_next = S_LOAD;
      S_LOAD:  state_next = S_CHECK;
      S_CHECK: begin
        if ((EARLY_EXIT != 0) && Z) begin
          state_next = S_DONE;
        end else if (LSB) begin
          state_next = S_ADD;
        end else begin
          state_next = S_SHIFT;
        end
      end
      S_ADD:   state_next = S_SHIFT;
      S_SHIFT: begin
        if (iter_reg == ITER_LAST) begin
          state_next = S_DONE;
        end else begin
          state_next = S_CHECK;
        end
      end
      S_DONE:  if (hold_expired) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (ABORT && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
    end
  end

  // Iteration count: zero whenever heading to IDLE, +1 per shift, saturating.
  always_comb begin
    iter_next = iter_reg;
    if (state_next == S_IDLE) begin
      iter_next = '0;
    end else if ((state_reg == S_SHIFT) && (iter_reg != ITER_FULL)) begin
      iter_next = iter_reg + 1'b1;
    end
  end

  // Iteration counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter_reg <= '0;
    end else begin
      iter_reg <= iter_next;
    end
  end

  // Moore output decode; unknown encodings drive everything low.
  always_comb begin
    LD      = 1'b0;
    RST_ACC = 1'b0;
    ADD     = 1'b0;
    SH      = 1'b0;
    DONE    = 1'b0;
    BUSY    = 1'b0;
    case (state_reg)
      S_LOAD: begin
        LD      = 1'b1;
        RST_ACC = 1'b1;
        BUSY    = 1'b1;
      end
      S_CHECK: BUSY = 1'b1;
      S_ADD: begin
        ADD  = 1'b1;
        BUSY = 1'b1;
      end
      S_SHIFT: begin
        SH   = 1'b1;
        BUSY = 1'b1;
      end
      S_DONE: begin
        DONE = 1'b1;
        BUSY = 1'b1;
      end
      default: ;
    endcase
  end

  assign ITER = iter_reg;

endmodule
